multicycle_ctrl: RTL and testbench

- Multi-cycle control FSM for the LEGv8 core. It sequences a shared-ALU, single-memory datapath through fetch, decode, execute, memory and writeback steps.
- Supported instructions: R-type (ADD/SUB/AND/ORR), LDUR, STUR and CBZ.
- Handles memory wait states through a req/ack handshake and traps illegal opcodes and memory timeouts.
- Replaces the single-cycle main decoder plus PC logic when the core is built in its multi-cycle variant.

---
 rtl/ctrl_pkg.sv | 54 +++++
 rtl/op_class.sv | 30 +++
 rtl/multicycle_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_pkg
//  Description : Shared types and encodings for the LEGv8 multi-cycle
//                controller: FSM state enumeration, opcode classes,
//                ALUSrcB / ALUOp encodings and opcode casez patterns.
//  Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    // Controller states (explicit 4-bit encoding)
    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        EXEC_R   = 4'd3,
        R_WB     = 4'd4,
        MEM_ADDR = 4'd5,
        MEM_RD   = 4'd6,
        MEM_WB   = 4'd7,
        MEM_WR   = 4'd8,
        BRANCH   = 4'd9,
        HALT     = 4'd10
    } state_t;

    // Instruction classes produced by the opcode decoder
    typedef enum logic [2:0] {
        OPC_R       = 3'd0,
        OPC_LD      = 3'd1,
        OPC_ST      = 3'd2,
        OPC_CBZ     = 3'd3,
        OPC_ILLEGAL = 3'd4
    } opclass_t;

    // ALU B-operand source select
    localparam logic [1:0] c_alub_reg  = 2'b00;  // register B
    localparam logic [1:0] c_alub_four = 2'b01;  // constant 4
    localparam logic [1:0] c_alub_imm  = 2'b10;  // sign-extended immediate
    localparam logic [1:0] c_alub_br   = 2'b11;  // immediate << 2

    // ALU operation select
    localparam logic [1:0] c_aluop_add   = 2'b00;
    localparam logic [1:0] c_aluop_passb = 2'b01;
    localparam logic [1:0] c_aluop_funct = 2'b10;

    // Opcode patterns for casez ('?' positions are don't-care)
    localparam logic [10:0] c_op_r_a = 11'b1?0_0101_1000;  // ADD / SUB
    localparam logic [10:0] c_op_r_b = 11'b10?_0101_0000;  // AND / ORR
    localparam logic [10:0] c_op_ldur = 11'b111_1100_0010;
    localparam logic [10:0] c_op_stur = 11'b111_1100_0000;
    localparam logic [10:0] c_op_cbz  = 11'b101_1010_0???;

endpackage : ctrl_pkg
`default_nettype wire

// File: rtl/op_class.sv
`default_nettype none
// ============================================================================
//  Module      : op_class
//  Description : Combinational opcode classifier. Maps the 11-bit LEGv8
//                opcode field to one of R / LD / ST / CBZ / ILLEGAL.
//  Ports       : i_op  [10:0] in  - IR[31:21]
//                o_cls [2:0]  out - instruction class (opclass_t)
//  Revision    : 1.0 - initial release
// ============================================================================
module op_class
    import ctrl_pkg::*;
(
    input  logic [10:0] i_op,
    output opclass_t    o_cls
);

    always_comb begin
        o_cls = OPC_ILLEGAL;
        casez (i_op)
            c_op_r_a,
            c_op_r_b:  o_cls = OPC_R;
            c_op_ldur: o_cls = OPC_LD;
            c_op_stur: o_cls = OPC_ST;
            c_op_cbz:  o_cls = OPC_CBZ;
            default:   o_cls = OPC_ILLEGAL;
        endcase
    end

endmodule : op_class
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Multi-cycle control FSM for the LEGv8 core. Sequences a
//                shared-ALU / single-memory datapath through fetch, decode,
//                execute, memory and writeback, with req/ack memory wait
//                states, illegal-opcode trapping and a memory timeout.
//  Ports       : clk, reset (async, active-high)
//                Op[10:0], Zero, mem_ack                      - inputs
//                PCWrite, PCSrc, IorD, IRWrite, Reg2Loc,
//                ALUSrcA, ALUSrcB[1:0], ALUOp[1:0], MemRead,
//                MemWrite, MemtoReg, RegWrite                 - datapath ctl
//                instr_done, illegal (pulses), fault (sticky) - status
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] Op,
    input  logic        Zero,
    input  logic        mem_ack,
    output logic        PCWrite,
    output logic        PCSrc,
    output logic        IorD,
    output logic        IRWrite,
    output logic        Reg2Loc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        instr_done,
    output logic        illegal,
    output logic        fault
);

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic [CNT_W-1:0]   w_wait_cnt_next;
    logic [CNT_W-1:0]   w_wait_cnt_inc;
    logic               w_timeout;
    logic               r_fault;
    logic               w_fault_next;
    opclass_t           w_cls;

    op_class u_op_class (
        .i_op  (Op),
        .o_cls (w_cls)
    );

    assign w_wait_cnt_inc = r_wait_cnt + 1'b1;
    assign w_timeout      = (w_wait_cnt_inc == CNT_W'(TIMEOUT));
    assign fault          = r_fault;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
            r_fault    <= w_fault_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        // The counter is zero everywhere except while stalled on memory,
        // so it is already clear on entry to any wait state.
        w_wait_cnt_next = '0;
        w_fault_next    = r_fault;
        PCWrite         = 1'b0;
        PCSrc           = 1'b0;
        IorD            = 1'b0;
        IRWrite         = 1'b0;
        Reg2Loc         = 1'b0;
        ALUSrcA         = 1'b0;
        ALUSrcB         = c_alub_reg;
        ALUOp           = c_aluop_add;
        MemRead         = 1'b0;
        MemWrite        = 1'b0;
        MemtoReg        = 1'b0;
        RegWrite        = 1'b0;
        instr_done      = 1'b0;
        illegal         = 1'b0;

        // Shared stall handling for FETCH / MEM_RD / MEM_WR. An ack in the
        // same cycle the count would hit TIMEOUT takes precedence.
        if ((r_state == FETCH || r_state == MEM_RD || r_state == MEM_WR) && !mem_ack) begin
            w_wait_cnt_next = w_wait_cnt_inc;
            if (w_timeout) begin
                w_fault_next = 1'b1;
                w_state_next = HALT;
            end
        end

        case (r_state)
            IDLE: begin
                w_state_next = FETCH;
            end
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = c_alub_four;
                if (mem_ack) begin
                    IRWrite      = 1'b1;
                    PCWrite      = 1'b1;
                    w_state_next = DECODE;
                end
            end
            DECODE: begin
                ALUSrcB = c_alub_br;
                Reg2Loc = (w_cls == OPC_ST) || (w_cls == OPC_CBZ);
                case (w_cls)
                    OPC_R:   w_state_next = EXEC_R;
                    OPC_LD,
                    OPC_ST:  w_state_next = MEM_ADDR;
                    OPC_CBZ: w_state_next = BRANCH;
                    default: begin
                        illegal      = 1'b1;
                        w_state_next = IDLE;
                    end
                endcase
            end
            EXEC_R: begin
                ALUSrcA      = 1'b1;
                ALUOp        = c_aluop_funct;
                w_state_next = R_WB;
            end
            R_WB: begin
                RegWrite     = 1'b1;
                ALUSrcA      = 1'b1;
                ALUOp        = c_aluop_funct;
                instr_done   = 1'b1;
                w_state_next = FETCH;
            end
            MEM_ADDR: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = c_alub_imm;
                Reg2Loc      = (w_cls == OPC_ST);
                w_state_next = (w_cls == OPC_ST) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ack) begin
                    w_state_next = MEM_WB;
                end
            end
            MEM_WB: begin
                RegWrite     = 1'b1;
                MemtoReg     = 1'b1;
                instr_done   = 1'b1;
                w_state_next = FETCH;
            end
            MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                Reg2Loc  = 1'b1;
                if (mem_ack) begin
                    instr_done   = 1'b1;
                    w_state_next = FETCH;
                end
            end
            BRANCH: begin
                Reg2Loc      = 1'b1;
                ALUSrcA      = 1'b1;
                ALUOp        = c_aluop_passb;
                PCWrite      = Zero;
                PCSrc        = Zero;
                instr_done   = 1'b1;
                w_state_next = FETCH;
            end
            HALT: begin
                w_state_next = HALT;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

endmodule : multicycle_ctrl
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_ctrl
//  Description : Directed self-checking bench for multicycle_ctrl. Each
//                step pushes the expected state and output vector into a
//                scoreboard queue; the entry is popped and compared at the
//                following falling clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;
    import ctrl_pkg::*;

    localparam logic [10:0] c_add  = 11'b10001011000;
    localparam logic [10:0] c_ldur = 11'b11111000010;
    localparam logic [10:0] c_stur = 11'b11111000000;
    localparam logic [10:0] c_cbz  = 11'b10110100101;
    localparam logic [16:0] c_quiet = 17'd0;
    localparam logic [16:0] c_halt  = 17'd1;   // only fault set

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] Op = 11'd0;
    logic        Zero = 1'b0;
    logic        mem_ack = 1'b0;
    logic        PCWrite, PCSrc, IorD, IRWrite, Reg2Loc, ALUSrcA;
    logic [1:0]  ALUSrcB, ALUOp;
    logic        MemRead, MemWrite, MemtoReg, RegWrite;
    logic        instr_done, illegal, fault;
    logic [16:0] w_obs;

    always #5 clk = ~clk;

    multicycle_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .Op         (Op),
        .Zero       (Zero),
        .mem_ack    (mem_ack),
        .PCWrite    (PCWrite),
        .PCSrc      (PCSrc),
        .IorD       (IorD),
        .IRWrite    (IRWrite),
        .Reg2Loc    (Reg2Loc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .instr_done (instr_done),
        .illegal    (illegal),
        .fault      (fault)
    );

    assign w_obs = {PCWrite, PCSrc, IorD, IRWrite, Reg2Loc, ALUSrcA, ALUSrcB, ALUOp,
                    MemRead, MemWrite, MemtoReg, RegWrite, instr_done, illegal, fault};

    typedef struct {
        string       tag;
        state_t      st;
        logic [16:0] v;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [16:0] ov(
        input logic pcw, input logic pcs, input logic iord, input logic irw,
        input logic r2l, input logic asa, input logic [1:0] asb, input logic [1:0] aop,
        input logic mr, input logic mw, input logic m2r, input logic rw,
        input logic done, input logic ill, input logic flt);
        return {pcw, pcs, iord, irw, r2l, asa, asb, aop, mr, mw, m2r, rw, done, ill, flt};
    endfunction

    function automatic logic [16:0] f_fetch(input logic a);
        return ov(a, 1'b0, 1'b0, a, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic logic [16:0] f_dec(input logic r2l, input logic ill);
        return ov(1'b0, 1'b0, 1'b0, 1'b0, r2l, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ill, 1'b0);
    endfunction
    function automatic logic [16:0] f_exec();
        return ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic logic [16:0] f_rwb();
        return ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    endfunction
    function automatic logic [16:0] f_maddr(input logic r2l);
        return ov(1'b0, 1'b0, 1'b0, 1'b0, r2l, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic logic [16:0] f_mrd();
        return ov(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic logic [16:0] f_mwb();
        return ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    endfunction
    function automatic logic [16:0] f_mwr(input logic a);
        return ov(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, a, 1'b0, 1'b0);
    endfunction
    function automatic logic [16:0] f_br(input logic z);
        return ov(z, z, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endfunction

    task automatic push_exp(input string tag, input state_t st, input logic [16:0] v);
        exp_t e;
        e.tag = tag;
        e.st  = st;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic observe();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_empty: observed=empty required=entry");
            return;
        end
        e = sb.pop_front();
        assert (dut.r_state === e.st) else begin
            failures++;
            $error("FAIL %s state: observed=%0d expected=%0d", e.tag, dut.r_state, e.st);
        end
        checks++;
        assert (w_obs === e.v) else begin
            failures++;
            $error("FAIL %s outputs: observed=%b expected=%b", e.tag, w_obs, e.v);
        end
    endtask

    // One clock step: expectation for the current cycle, sample on the
    // falling edge, then move to just after the next rising edge.
    task automatic cyc(input string tag, input state_t st, input logic [16:0] v);
        push_exp(tag, st, v);
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        push_exp("rst_idle", IDLE, c_quiet);
        observe();

        // ADD with memory always ready: 4 cycles per instruction
        reset   = 1'b0;
        mem_ack = 1'b1;
        Op      = c_add;
        cyc("add_idle",  IDLE,   c_quiet);
        cyc("add_fetch", FETCH,  f_fetch(1'b1));
        cyc("add_dec",   DECODE, f_dec(1'b0, 1'b0));
        cyc("add_exec",  EXEC_R, f_exec());
        cyc("add_wb",    R_WB,   f_rwb());

        // LDUR with two wait cycles in FETCH and in MEM_RD
        Op      = c_ldur;
        mem_ack = 1'b0;
        cyc("ld_fetch_w1", FETCH, f_fetch(1'b0));
        cyc("ld_fetch_w2", FETCH, f_fetch(1'b0));
        mem_ack = 1'b1;
        cyc("ld_fetch_ack", FETCH, f_fetch(1'b1));
        mem_ack = 1'b0;
        cyc("ld_dec",   DECODE,   f_dec(1'b0, 1'b0));
        cyc("ld_addr",  MEM_ADDR, f_maddr(1'b0));
        cyc("ld_rd_w1", MEM_RD,   f_mrd());
        cyc("ld_rd_w2", MEM_RD,   f_mrd());
        mem_ack = 1'b1;
        cyc("ld_rd_ack", MEM_RD,  f_mrd());
        cyc("ld_wb",     MEM_WB,  f_mwb());

        // CBZ taken then not taken
        Op   = c_cbz;
        Zero = 1'b1;
        cyc("cbz1_fetch", FETCH,  f_fetch(1'b1));
        cyc("cbz1_dec",   DECODE, f_dec(1'b1, 1'b0));
        cyc("cbz1_br",    BRANCH, f_br(1'b1));
        Zero = 1'b0;
        cyc("cbz0_fetch", FETCH,  f_fetch(1'b1));
        cyc("cbz0_dec",   DECODE, f_dec(1'b1, 1'b0));
        cyc("cbz0_br",    BRANCH, f_br(1'b0));

        // Illegal opcode: pulse in DECODE, back through IDLE
        Op = 11'd0;
        cyc("ill_fetch",  FETCH,  f_fetch(1'b1));
        cyc("ill_dec",    DECODE, f_dec(1'b0, 1'b1));
        cyc("ill_idle",   IDLE,   c_quiet);
        cyc("ill_fetch2", FETCH,  f_fetch(1'b1));

        // STUR with no ack: timeout after 4 wait cycles into HALT
        Op = c_stur;
        cyc("st_to_dec",  DECODE,   f_dec(1'b1, 1'b0));
        cyc("st_to_addr", MEM_ADDR, f_maddr(1'b1));
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) cyc("st_to_wait", MEM_WR, f_mwr(1'b0));
        for (int i = 0; i < 3; i++) begin
            mem_ack = (i == 1);
            cyc("st_halt", HALT, c_halt);
        end
        reset = 1'b1;
        #1;
        push_exp("halt_rst", IDLE, c_quiet);
        observe();
        @(posedge clk);
        #1;
        reset   = 1'b0;
        mem_ack = 1'b1;

        // STUR with ack on the 4th wait cycle: no fault
        cyc("st4_idle",  IDLE,     c_quiet);
        cyc("st4_fetch", FETCH,    f_fetch(1'b1));
        cyc("st4_dec",   DECODE,   f_dec(1'b1, 1'b0));
        cyc("st4_addr",  MEM_ADDR, f_maddr(1'b1));
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) cyc("st4_wait", MEM_WR, f_mwr(1'b0));
        mem_ack = 1'b1;
        cyc("st4_ack",   MEM_WR, f_mwr(1'b1));
        cyc("st4_fetch2", FETCH, f_fetch(1'b1));

        // Asynchronous reset in the middle of MEM_WR
        cyc("rmid_dec",  DECODE,   f_dec(1'b1, 1'b0));
        cyc("rmid_addr", MEM_ADDR, f_maddr(1'b1));
        mem_ack = 1'b0;
        push_exp("rmid_wr", MEM_WR, f_mwr(1'b0));
        @(negedge clk);
        observe();
        reset = 1'b1;
        #1;
        push_exp("rmid_rst", IDLE, c_quiet);
        observe();
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc("rmid_idle",  IDLE,  c_quiet);
        cyc("rmid_fetch", FETCH, f_fetch(1'b0));

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: observed=%0d required=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_multicycle_ctrl
`default_nettype wire
